poly_envelope_generator: RTL and testbench

Multi-voice successor to the single-voice envelope/modulator path. Runs one ADSR state machine per voice from individual gate inputs, applies each envelope to that voice's sample, and sums the voices into one saturated mix. Sits between the oscillator bank and the audio output serializer, with valid/ready streaming on both sample sides.

---
 rtl/env_pkg.sv | 30 +++
 rtl/adsr_voice.sv | 89 ++++++++
 rtl/poly_envelope_generator.sv | 115 +++++++++++
 tb/tb_poly_envelope_generator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/env_pkg.sv
// Shared types and helpers for the polyphonic envelope generator.
package env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } adsr_state_e;

    // Full-scale envelope level for a given level width.
    function automatic logic [31:0] env_max(input int unsigned width);
        if (width >= 32) return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

    // Clamp x into the signed range of a width-bit value.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/adsr_voice.sv
// One voice: gate edge detection, ADSR state machine and envelope level register.
module adsr_voice
    import env_pkg::*;
#(
    parameter int unsigned ENV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 gate_i,
    input  logic [ENV_WIDTH-1:0] attack_step_i,
    input  logic [ENV_WIDTH-1:0] decay_step_i,
    input  logic [ENV_WIDTH-1:0] sustain_level_i,
    input  logic [ENV_WIDTH-1:0] release_step_i,
    output logic                 active_o,
    output logic [ENV_WIDTH-1:0] level_o
);

    localparam logic [ENV_WIDTH-1:0] LVL_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));

    adsr_state_e          state_q, state_d;
    logic [ENV_WIDTH-1:0] level_q, level_d;
    logic                 gate_q;
    logic                 active_q;
    logic                 rise, fall;
    logic [ENV_WIDTH:0]   attack_sum;

    // Next state and level; a gate edge pre-empts the level step of a coinciding tick.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        rise       = gate_i && !gate_q;
        fall       = !gate_i && gate_q;
        attack_sum = {1'b0, level_q} + {1'b0, attack_step_i};

        if (rise) begin
            state_d = ST_ATTACK;
        end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else if (tick_i) begin
            case (state_q)
                ST_ATTACK: begin
                    if (attack_step_i == '0 || attack_sum[ENV_WIDTH])
                        level_d = LVL_MAX;
                    else
                        level_d = attack_sum[ENV_WIDTH-1:0];
                    if (level_d == LVL_MAX) state_d = ST_DECAY;
                end
                ST_DECAY: begin
                    if (decay_step_i == '0 || level_q < decay_step_i ||
                        (level_q - decay_step_i) <= sustain_level_i)
                        level_d = sustain_level_i;
                    else
                        level_d = level_q - decay_step_i;
                    if (level_d == sustain_level_i) state_d = ST_SUSTAIN;
                end
                ST_SUSTAIN: level_d = sustain_level_i;
                ST_RELEASE: begin
                    if (release_step_i == '0 || level_q <= release_step_i) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - release_step_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            gate_q   <= gate_i;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign active_o = active_q;
    assign level_o  = level_q;

endmodule

// File: rtl/poly_envelope_generator.sv
// Multi-voice ADSR envelope generator with a two-stage modulate/mix stream pipeline.
module poly_envelope_generator
    import env_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ENV_WIDTH  = 16,
    parameter int unsigned TICK_DIV   = 256
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_VOICES-1:0]            gate_i,
    input  logic [ENV_WIDTH-1:0]             attack_step_i,
    input  logic [ENV_WIDTH-1:0]             decay_step_i,
    input  logic [ENV_WIDTH-1:0]             sustain_level_i,
    input  logic [ENV_WIDTH-1:0]             release_step_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [NUM_VOICES*DATA_WIDTH-1:0] sample_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            mix_o,
    output logic [NUM_VOICES-1:0]            voice_active_o,
    output logic [NUM_VOICES*ENV_WIDTH-1:0]  env_level_o
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PROD_W = DATA_WIDTH + ENV_WIDTH + 1;
    localparam int unsigned SUM_W  = DATA_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]                tick_cnt;
    logic                            tick;
    logic [NUM_VOICES*ENV_WIDTH-1:0] env_level;
    logic [NUM_VOICES-1:0]           voice_active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        adsr_voice #(.ENV_WIDTH(ENV_WIDTH)) u_voice (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .tick_i         (tick),
            .gate_i         (gate_i[v]),
            .attack_step_i  (attack_step_i),
            .decay_step_i   (decay_step_i),
            .sustain_level_i(sustain_level_i),
            .release_step_i (release_step_i),
            .active_o       (voice_active[v]),
            .level_o        (env_level[v*ENV_WIDTH +: ENV_WIDTH])
        );
    end

    assign voice_active_o = voice_active;
    assign env_level_o    = env_level;

    logic signed [PROD_W-1:0]     prod_c   [NUM_VOICES];
    logic signed [DATA_WIDTH-1:0] scaled_c [NUM_VOICES];
    logic signed [DATA_WIDTH-1:0] s1_scaled [NUM_VOICES];
    logic signed [SUM_W-1:0]      sum_c;
    logic [DATA_WIDTH-1:0]        mix_c;
    logic                         s1_valid, s2_valid;
    logic                         s1_en, s2_adv;
    logic [DATA_WIDTH-1:0]        mix_q;

    // Signed sample times unsigned level, floor-scaled back to sample width.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            prod_c[v]   = PROD_W'($signed(sample_i[v*DATA_WIDTH +: DATA_WIDTH])) *
                          PROD_W'($signed({1'b0, env_level[v*ENV_WIDTH +: ENV_WIDTH]}));
            scaled_c[v] = DATA_WIDTH'(prod_c[v] >>> ENV_WIDTH);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int v = 0; v < NUM_VOICES; v++) sum_c = sum_c + SUM_W'(s1_scaled[v]);
        mix_c = DATA_WIDTH'(saturate(64'(sum_c), DATA_WIDTH));
    end

    // S2 moves when empty or drained; S1 loads when empty or S2 takes its contents.
    assign s2_adv     = !s2_valid || out_ready_i;
    assign s1_en      = !s1_valid || s2_adv;
    assign in_ready_o = s1_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_scaled <= '{default: '0};
        end else if (s1_en) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) s1_scaled <= scaled_c;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            mix_q    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) mix_q <= mix_c;
        end
    end

    assign out_valid_o = s2_valid;
    assign mix_o       = mix_q;

endmodule

// File: tb/tb_poly_envelope_generator.sv
// Directed bench for poly_envelope_generator: ADSR sequencing, modulation/mix and stream handshake.
module tb_poly_envelope_generator;

    logic        clk;
    logic        rst_n;
    logic [3:0]  gate;
    logic [15:0] attack_step, decay_step, sustain_level, release_step;
    logic        in_valid, in_ready;
    logic [95:0] sample;
    logic        out_valid, out_ready;
    logic [23:0] mix;
    logic [3:0]  active;
    logic [63:0] env;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] ADS_SEQ [12] = '{
        16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF, 16'hDFFF,
        16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000
    };

    poly_envelope_generator #(
        .NUM_VOICES(4), .DATA_WIDTH(24), .ENV_WIDTH(16), .TICK_DIV(1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .gate_i         (gate),
        .attack_step_i  (attack_step),
        .decay_step_i   (decay_step),
        .sustain_level_i(sustain_level),
        .release_step_i (release_step),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .sample_i       (sample),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .mix_o          (mix),
        .voice_active_o (active),
        .env_level_o    (env)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int   seq_in, seq_out, n_acc;
    logic acc, xfer;

    initial begin
        rst_n         = 1'b0;
        gate          = 4'b0000;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'h8000;
        release_step  = 16'h3000;
        in_valid      = 1'b0;
        sample        = '0;
        out_ready     = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mix", 64'(mix), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_env", env, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("idle_after_rst", 64'(active), 64'd0);

        // Attack to full scale, decay into sustain.
        gate = 4'b0001;
        cyc(1);
        chk("gate_active", 64'(active), 64'd1);
        chk("rise_no_step", 64'(env[15:0]), 64'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("ads_level", 64'(env[15:0]), 64'(ADS_SEQ[i]));
        end
        cyc(2);
        chk("sustain_hold", 64'(env[15:0]), 64'h8000);

        // Release to idle.
        gate = 4'b0000;
        cyc(1);
        chk("fall_no_step", 64'(env[15:0]), 64'h8000);
        chk("rel_active", 64'(active), 64'd1);
        cyc(1);
        chk("rel_5000", 64'(env[15:0]), 64'h5000);
        cyc(1);
        chk("rel_2000", 64'(env[15:0]), 64'h2000);
        cyc(1);
        chk("rel_0000", 64'(env[15:0]), 64'h0000);
        chk("rel_idle", 64'(active), 64'd0);

        // Retrigger during release continues from the current level.
        gate = 4'b0001;
        cyc(14);
        chk("re_sustain", 64'(env[15:0]), 64'h8000);
        gate = 4'b0000;
        cyc(3);
        chk("re_rel_2000", 64'(env[15:0]), 64'h2000);
        gate = 4'b0001;
        cyc(1);
        chk("retrig_level", 64'(env[15:0]), 64'h2000);
        chk("retrig_active", 64'(active), 64'd1);
        cyc(1);
        chk("retrig_attack", 64'(env[15:0]), 64'h6000);

        // All voices to full scale.
        sustain_level = 16'hFFFF;
        gate = 4'b1111;
        cyc(9);
        chk("all_full", env, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("all_active", 64'(active), 64'hF);

        // Pipeline latency, saturation and floor scaling.
        in_valid = 1'b1;
        sample   = {4{24'h7FFFFF}};
        cyc(1);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        sample = {4{24'h800000}};
        cyc(1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("sat_pos", 64'(mix), 64'h7FFFFF);
        sample = {24'h0, 24'h0, 24'hFFFF00, 24'h000100};
        cyc(1);
        chk("sat_neg", 64'(mix), 64'h800000);
        in_valid = 1'b0;
        cyc(1);
        chk("floor_mix", 64'(mix), 64'hFFFFFF);
        cyc(1);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Streaming with a 5-cycle downstream stall; sequence-ordered delivery.
        seq_in  = 1;
        seq_out = 1;
        n_acc   = 0;
        for (int c = 0; c < 25; c++) begin
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (c < 18);
            sample    = {72'h0, 24'(seq_in * 256)};
            #1;
            if (c == 8 || c == 10) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(mix), 64'(24'(seq_out * 256 - 1)));
            end
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                chk("seq_mix", 64'(mix), 64'(24'(seq_out * 256 - 1)));
                seq_out++;
            end
            if (acc) begin
                seq_in++;
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        chk("all_delivered", 64'(seq_out), 64'(seq_in));
        chk("accept_count", 64'(n_acc), 64'd13);

        // Reset mid-stream.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sample    = {72'h0, 24'h000500};
        cyc(3);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        gate  = 4'b0000;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_mix", 64'(mix), 64'd0);
        chk("mid_rst_active", 64'(active), 64'd0);
        chk("mid_rst_env", env, 64'd0);
        cyc(1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc(2);
        chk("post_rst_idle", 64'(active), 64'd0);
        chk("post_rst_env", env, 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
